// File: rtl/rv_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_defs (package)
//  Description : Shared fetch-side definitions: data width, NOP encoding,
//                default reset PC and fetch state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_defs;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,
    FS_REQ  = 3'd1,
    FS_WAIT = 3'd2,
    FS_HOLD = 3'd3,
    FS_DROP = 3'd4
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : One-entry {instr, pc} holding buffer used when a response
//                arrives while decode is stalled.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                flush_i         - discard contents (highest priority)
//                load_i          - capture instr_i/pc_i
//                unload_i        - mark entry consumed
//                valid_o/instr_o/pc_o - buffered entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import rv_defs::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch: owns the PC, issues word reads to
//                instruction memory and presents {instr, pc} to decode with a
//                valid/ready handshake. Execute may redirect at any time.
//  Ports       : imem_*      - request/response to instruction memory
//                redirect_*  - taken branch/jump from execute
//                if_*_o      - fetched instruction toward decode
//                dec_ready_i - decode accepts when if_valid_o is high
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import rv_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            dec_ready_i
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;

  logic            skid_load, skid_unload, skid_flush, skid_valid;
  logic [XLEN-1:0] skid_instr, skid_pc;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (skid_flush),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .instr_i  (imem_rdata_i),
    .pc_i     (pc_q),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    // Plain consume; a load below overrides it in the same cycle.
    if (if_valid_q && dec_ready_i) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ: begin
        if (imem_ready_i) state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_rvalid_i) begin
          pc_d    = pc_q + 32'd4;
          state_d = FS_REQ;
          if (!if_valid_q || dec_ready_i) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata_i;
            if_pc_d    = pc_q;
          end else begin
            skid_load = 1'b1;
            state_d   = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (dec_ready_i && skid_valid) begin
          if_valid_d  = 1'b1;
          if_instr_d  = skid_instr;
          if_pc_d     = skid_pc;
          skid_unload = 1'b1;
          state_d     = FS_REQ;
        end
      end
      FS_DROP: begin
        if (imem_rvalid_i) state_d = FS_REQ;
      end
      default: state_d = FS_IDLE;
    endcase

    // Redirect wins over everything; track whether a response is still in
    // flight so it can be discarded rather than delivered.
    if (redirect_valid_i) begin
      pc_d        = {redirect_pc_i[XLEN-1:2], 2'b00};
      if_valid_d  = 1'b0;
      skid_flush  = 1'b1;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      if ((state_q == FS_WAIT && !imem_rvalid_i) ||
          (state_q == FS_REQ  && imem_ready_i)   ||
          (state_q == FS_DROP && !imem_rvalid_i)) begin
        state_d = FS_DROP;
      end else begin
        state_d = FS_REQ;
      end
    end
  end

  assign imem_req_o  = (state_q == FS_REQ);
  assign imem_addr_o = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_instr_o  = if_instr_q;
  assign if_pc_o     = if_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage with a simple
//                instruction memory model of programmable response latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        dec_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // memory model state
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          mem_lat = 1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ready_i     (imem_ready),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .if_valid_o       (if_valid),
    .if_instr_o       (if_instr),
    .if_pc_o          (if_pc),
    .dec_ready_i      (dec_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], 8'h00};
  endfunction

  // One response per accepted request, mem_lat cycles after accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pend <= 1'b0;
      mem_addr <= '0;
      mem_cnt  <= 0;
    end else begin
      if (mem_pend) begin
        if (mem_cnt == 1) mem_pend <= 1'b0;
        else              mem_cnt  <= mem_cnt - 1;
      end
      if (imem_req && imem_ready) begin
        mem_pend <= 1'b1;
        mem_addr <= imem_addr;
        mem_cnt  <= mem_lat;
      end
    end
  end

  assign imem_rvalid = mem_pend && (mem_cnt == 1);
  assign imem_rdata  = mem_word(mem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT one clock before its IDLE->REQ edge.
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values ----------------
    mem_lat = 1; imem_ready = 1'b1; dec_ready = 1'b1;
    rst_n = 1'b0;
    step(); step();
    check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
    check_eq("rst_addr",  imem_addr, 32'h0);
    check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_instr", if_instr, NOP);
    check_eq("rst_pc",    if_pc, 32'h0);

    // ---------------- 1: basic latency/throughput ----------------
    rst_n = 1'b1;
    step();                                   // edge1: IDLE->REQ
    check_eq("t1_req1",  {31'd0, imem_req}, 32'd1);
    check_eq("t1_addr0", imem_addr, 32'h0);
    step();                                   // edge2: accepted
    check_eq("t1_wait_noreq", {31'd0, imem_req}, 32'd0);
    check_eq("t1_valid_c2",   {31'd0, if_valid}, 32'd0);
    step();                                   // edge3: first instr
    check_eq("t1_valid_c3", {31'd0, if_valid}, 32'd1);
    check_eq("t1_pc0",      if_pc, 32'h0);
    check_eq("t1_instr0",   if_instr, 32'h0050_0093);
    check_eq("t1_addr4",    imem_addr, 32'h4);
    step();                                   // edge4: consumed, accept 4
    check_eq("t1_consumed", {31'd0, if_valid}, 32'd0);
    step();                                   // edge5
    check_eq("t1_pc4",    if_pc, 32'h4);
    check_eq("t1_instr4", if_instr, 32'h0050_0493);
    check_eq("t1_addr8",  imem_addr, 32'h8);

    // ---------------- 2: decode stall, skid ----------------
    do_reset();
    step(); step(); step();                   // edge3: pc0 valid
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t2_hold_pc",    if_pc, 32'h0);
      check_eq("t2_hold_instr", if_instr, 32'h0050_0093);
      if (i >= 1) check_eq("t2_no_req", {31'd0, imem_req}, 32'd0);
    end
    dec_ready = 1'b1;
    step();                                   // skid -> output
    check_eq("t2_valid_skid", {31'd0, if_valid}, 32'd1);
    check_eq("t2_pc_skid",    if_pc, 32'h4);
    check_eq("t2_instr_skid", if_instr, 32'h0050_0493);
    check_eq("t2_next_addr",  imem_addr, 32'h8);
    check_eq("t2_next_req",   {31'd0, imem_req}, 32'd1);

    // ---------------- 3: redirect in WAIT, response dropped ----------------
    mem_lat = 3;
    do_reset();
    step(); step();                           // edge2: accepted, WAIT
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();                                   // edge3: -> DROP
    redirect_valid = 1'b0;
    check_eq("t3_drop_noreq", {31'd0, imem_req}, 32'd0);
    check_eq("t3_drop_valid", {31'd0, if_valid}, 32'd0);
    step();                                   // edge4
    check_eq("t3_drop_noreq2", {31'd0, imem_req}, 32'd0);
    step();                                   // edge5: stale data discarded
    check_eq("t3_stale_valid", {31'd0, if_valid}, 32'd0);
    check_eq("t3_req",         {31'd0, imem_req}, 32'd1);
    check_eq("t3_addr",        imem_addr, 32'h0000_0100);
    step(); step(); step(); step();           // edge9: new data
    check_eq("t3_valid", {31'd0, if_valid}, 32'd1);
    check_eq("t3_pc",    if_pc, 32'h0000_0100);
    check_eq("t3_instr", if_instr, 32'h0051_0093);

    // ---------------- 4: redirect with skid full / same-cycle rvalid ----------------
    mem_lat = 1;
    do_reset();
    step(); step(); step();                   // edge3: pc0 valid
    dec_ready = 1'b0;
    step(); step();                           // edge5: pc4 in skid, HOLD
    check_eq("t4_hold_noreq", {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();                                   // edge6
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    check_eq("t4_valid_cleared", {31'd0, if_valid}, 32'd0);
    check_eq("t4_req",  {31'd0, imem_req}, 32'd1);
    check_eq("t4_addr", imem_addr, 32'h0000_0200);
    step();                                   // edge7: accepted
    check_eq("t4_no_skid_out", {31'd0, if_valid}, 32'd0);
    step();                                   // edge8
    check_eq("t4_pc", if_pc, 32'h0000_0200);
    step();                                   // edge9: accept 204, rvalid now
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step();                                   // edge10
    redirect_valid = 1'b0;
    check_eq("t4_rv_drop_valid", {31'd0, if_valid}, 32'd0);
    check_eq("t4_rv_req",        {31'd0, imem_req}, 32'd1);
    check_eq("t4_rv_addr",       imem_addr, 32'h0000_0300);

    // ---------------- 5: memory backpressure ----------------
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t5_req_held",  {31'd0, imem_req}, 32'd1);
      check_eq("t5_addr_held", imem_addr, 32'h0);
    end
    imem_ready = 1'b1;
    step();                                   // accept
    check_eq("t5_accepted", {31'd0, imem_req}, 32'd0);
    step();
    check_eq("t5_valid", {31'd0, if_valid}, 32'd1);
    check_eq("t5_pc",    if_pc, 32'h0);

    // ---------------- 6: PC wrap and async reset ----------------
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();                                   // edge1
    redirect_valid = 1'b0;
    check_eq("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(); step();                           // edge3
    check_eq("t6_pc_top",    if_pc, 32'hFFFF_FFFC);
    check_eq("t6_instr_top", if_instr, 32'hFFAF_FC93);
    check_eq("t6_addr_wrap", imem_addr, 32'h0);
    step(); step();                           // edge5
    check_eq("t6_pc_wrap", if_pc, 32'h0);
    dec_ready = 1'b0;
    step();                                   // edge6: WAIT on addr 4
    check_eq("t6_pre_addr", imem_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_req",   {31'd0, imem_req}, 32'd0);
    check_eq("t6_async_addr",  imem_addr, 32'h0);
    check_eq("t6_async_valid", {31'd0, if_valid}, 32'd0);
    check_eq("t6_async_instr", if_instr, NOP);
    check_eq("t6_async_pc",    if_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
